// File: rtl/uart_mat_loader.sv
// uart_mat_loader: decodes single-byte UART commands, streams N*N operand
// bytes into the A/B buffers, and hands off to the matrix engine with a
// start pulse, holding further commands until the engine reports done.
module uart_mat_loader #(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ADDR_W         = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              eng_done,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              eng_start,
    output logic              busy,
    output logic              a_loaded,
    output logic              b_loaded,
    output logic              err
);

    localparam logic [7:0] CMD_LOAD_A = 8'hA1;
    localparam logic [7:0] CMD_LOAD_B = 8'hB1;
    localparam logic [7:0] CMD_START  = 8'hC1;

    // Idle counter runs 0..TIMEOUT_CYCLES-1; reaching the top with no byte aborts.
    localparam int              TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(N*N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_DONE
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] elem_cnt, elem_cnt_next;
    logic [TO_W-1:0]   idle_cnt, idle_cnt_next;

    logic              wr_en_next;
    logic              wr_sel_next;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [7:0]        wr_data_next;
    logic              eng_start_next;
    logic              a_loaded_next;
    logic              b_loaded_next;
    logic              err_next;

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output decode for the command sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next     = state;
        elem_cnt_next  = elem_cnt;
        idle_cnt_next  = idle_cnt;
        wr_en_next     = 1'b0;
        wr_sel_next    = wr_sel;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        eng_start_next = 1'b0;
        a_loaded_next  = a_loaded;
        b_loaded_next  = b_loaded;
        err_next       = 1'b0;

        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD_A, CMD_LOAD_B: begin
                            wr_sel_next   = (rx_data == CMD_LOAD_B);
                            elem_cnt_next = '0;
                            idle_cnt_next = '0;
                            if (rx_data == CMD_LOAD_B) begin
                                b_loaded_next = 1'b0;
                            end else begin
                                a_loaded_next = 1'b0;
                            end
                            state_next = S_LOAD;
                        end
                        CMD_START: begin
                            if (a_loaded && b_loaded) begin
                                eng_start_next = 1'b1;
                                state_next     = S_START;
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end

            S_LOAD: begin
                if (rx_valid) begin
                    // Data bytes are raw here: command values are written, not decoded.
                    wr_en_next    = 1'b1;
                    wr_addr_next  = elem_cnt;
                    wr_data_next  = rx_data;
                    idle_cnt_next = '0;
                    if (elem_cnt == LAST_ELEM) begin
                        if (wr_sel) begin
                            b_loaded_next = 1'b1;
                        end else begin
                            a_loaded_next = 1'b1;
                        end
                        state_next = S_IDLE;
                    end else begin
                        elem_cnt_next = elem_cnt + 1'b1;
                    end
                end else if (idle_cnt == TO_LAST) begin
                    // Abandon the partial matrix; its loaded flag stays low.
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    idle_cnt_next = idle_cnt + 1'b1;
                end
            end

            S_START: begin
                state_next = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                // Received bytes are dropped silently while the engine runs.
                if (eng_done) begin
                    state_next = S_IDLE;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // Registered outputs and load counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt  <= '0;
            idle_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_sel    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            eng_start <= 1'b0;
            busy      <= 1'b0;
            a_loaded  <= 1'b0;
            b_loaded  <= 1'b0;
            err       <= 1'b0;
        end else begin
            elem_cnt  <= elem_cnt_next;
            idle_cnt  <= idle_cnt_next;
            wr_en     <= wr_en_next;
            wr_sel    <= wr_sel_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
            eng_start <= eng_start_next;
            busy      <= (state_next != S_IDLE);
            a_loaded  <= a_loaded_next;
            b_loaded  <= b_loaded_next;
            err       <= err_next;
        end
    end

endmodule
